pio_in_edge: RTL and testbench

Parametrised Avalon-MM input PIO for board switches and push-buttons on the Nios system bus. It is the successor to the fixed 8-bit switch port and adds:
- configurable width,
- a per-bit input synchroniser and debounce filter,
- per-bit edge capture with write-1-to-clear,
- a maskable level interrupt to the Nios IRQ controller.

Reads are side-effect free, with one-cycle registered read latency as on the existing PIOs.

---
 rtl/pio_in_pkg.sv | 22 ++
 rtl/pio_in_filter_bit.sv | 81 ++++++++
 rtl/pio_in_edge.sv | 127 ++++++++++++
 tb/tb_pio_in_edge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants and types for the parametrised Avalon-MM input PIO.
package pio_in_pkg;

   // Register map (word addresses on the 2-bit address bus)
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // EDGE_MODE encodings
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Init sequencer: wait for the synchronisers to fill, load once, then run
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } init_state_e;

endpackage

// File: rtl/pio_in_filter_bit.sv
// One input bit: synchroniser chain, debounce counter, filtered value and
// its one-cycle-delayed copy used for edge detection.
module pio_in_filter_bit
   import pio_in_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pin,
   input  init_state_e state,
   output logic        stable,
   output logic        stable_prev
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   // stable_q is the accepted (filtered) value; stable_dly_q is that value one cycle later
   logic                   stable_q, stable_d;
   logic                   stable_dly_q, stable_dly_d;
   logic                   s;

   assign s           = sync_q[SYNC_STAGES-1];
   assign stable      = stable_q;
   assign stable_prev = stable_dly_q;

   // Shift the raw pin into the synchroniser chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin};
   end

   // Debounce: accept a change only after it has held long enough; LOAD seeds both copies
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      cnt_d        = cnt_q;
      stable_d     = stable_q;
      stable_dly_d = stable_dly_q;
      case (state)
         ST_LOAD: begin
            stable_d     = s;
            stable_dly_d = s;
            cnt_d        = '0;
         end
         ST_RUN: begin
            stable_dly_d = stable_q;
            if (DEBOUNCE_CYCLES == 0) begin
               stable_d = s;
            end else if (s == stable_q) begin
               cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
               stable_d = s;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Per-bit state registers
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: reset is asynchronous active-low; all state uses non-blocking assignments so flops update together.
      if (!reset_n) begin
         sync_q       <= '0;
         cnt_q        <= '0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
      end
   end

endmodule

// File: rtl/pio_in_edge.sv
// Avalon-MM input PIO: filtered inputs, per-bit edge capture with
// write-1-to-clear, maskable level interrupt, registered read data.
module pio_in_edge
   import pio_in_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   localparam int INIT_W = $clog2(SYNC_STAGES + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES - 1);

   init_state_e       state_q, state_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic              edge_en;

   logic [WIDTH-1:0]  stable, stable_prev;
   logic [WIDTH-1:0]  rise, fall, edge_hit, clr;
   logic [WIDTH-1:0]  edgecap_q, edgecap_d;
   logic [WIDTH-1:0]  irqmask_q, irqmask_d;
   logic [WIDTH-1:0]  readdata_q, readdata_d;
   logic              irq_q, irq_d;
   logic              wr_en;

   assign readdata = readdata_q;
   assign irq      = irq_q;

   // Init FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Init FSM next state: let the synchronisers fill, load once, then run forever
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) state_d = ST_LOAD;
            else                         init_cnt_d = init_cnt_q + INIT_W'(1);
         end
         ST_LOAD: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Init FSM outputs: edges only count once both filtered copies are valid
   always_comb begin
      edge_en = (state_q == ST_RUN);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_in_filter_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
         .clk        (clk),
         .reset_n    (reset_n),
         .pin        (in_port[i]),
         .state      (state_q),
         .stable     (stable[i]),
         .stable_prev(stable_prev[i])
      );
   end

   // Edge select, register writes, read mux and interrupt
   always_comb begin
      rise = stable & ~stable_prev;
      fall = ~stable & stable_prev;
      case (EDGE_MODE)
         EDGE_RISE: edge_hit = rise;
         EDGE_FALL: edge_hit = fall;
         default:   edge_hit = rise | fall;
      endcase
      if (!edge_en) edge_hit = '0;

      wr_en     = chipselect && !write_n;
      clr       = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;
      // A new edge on the same cycle as its clear keeps the bit set
      edgecap_d = (edgecap_q & ~clr) | edge_hit;
      irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata : irqmask_q;

      case (address)
         ADDR_DATA:    readdata_d = stable;
         ADDR_RSVD:    readdata_d = '0;
         ADDR_IRQMASK: readdata_d = irqmask_q;
         ADDR_EDGECAP: readdata_d = edgecap_q;
         default:      readdata_d = '0;
      endcase

      irq_d = |(edgecap_q & irqmask_q);
   end

   // Register file, read data and interrupt flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap_q  <= '0;
         irqmask_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_pio_in_edge.sv
// Self-checking bench for pio_in_edge: three instances cover the default
// configuration, a debounced configuration and a 16-bit any-edge one.
module tb_pio_in_edge;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Instance A: WIDTH 8, no debounce, rising edges
   logic [1:0]  addr_a;
   logic        cs_a, wrn_a, irq_a;
   logic [7:0]  wd_a, in_a, rd_a;
   // Instance B: WIDTH 8, DEBOUNCE_CYCLES 4, rising edges
   logic [1:0]  addr_b;
   logic        cs_b, wrn_b, irq_b;
   logic [7:0]  wd_b, in_b, rd_b;
   // Instance C: WIDTH 16, any edge
   logic [1:0]  addr_c;
   logic        cs_c, wrn_c, irq_c;
   logic [15:0] wd_c, in_c, rd_c;

   pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .address(addr_a), .chipselect(cs_a), .write_n(wrn_a),
      .writedata(wd_a), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

   pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .address(addr_b), .chipselect(cs_b), .write_n(wrn_b),
      .writedata(wd_b), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

   pio_in_edge #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .address(addr_c), .chipselect(cs_c), .write_n(wrn_c),
      .writedata(wd_c), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

   typedef struct {
      logic [7:0] in;
      logic [1:0] addr;
      logic       wr;
      logic [7:0] wd;
      logic [7:0] rd;
      logic       irq;
   } vec_t;

   vec_t vecs [0:30];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // One row per clock: inputs before the edge, registered outputs after it
      vecs[0]  = '{8'hFE, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[1]  = '{8'hFE, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[2]  = '{8'hFE, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[3]  = '{8'hFE, 2'd0, 1'b0, 8'h00, 8'hFE, 1'b0};
      vecs[4]  = '{8'hFE, 2'd2, 1'b1, 8'h01, 8'h00, 1'b0};
      vecs[5]  = '{8'hFE, 2'd2, 1'b0, 8'h00, 8'h01, 1'b0};
      vecs[6]  = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[7]  = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[10] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h01, 1'b1};
      vecs[11] = '{8'hFF, 2'd3, 1'b1, 8'h01, 8'h01, 1'b1};
      vecs[12] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[13] = '{8'hFF, 2'd0, 1'b1, 8'h00, 8'hFF, 1'b0};
      vecs[14] = '{8'hFF, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[15] = '{8'hFF, 2'd1, 1'b1, 8'hAA, 8'h00, 1'b0};
      vecs[16] = '{8'hFE, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[17] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[18] = '{8'hFE, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[19] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[20] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[21] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h01, 1'b1};
      vecs[22] = '{8'hFF, 2'd3, 1'b1, 8'h01, 8'h01, 1'b1};
      vecs[23] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h01, 1'b1};
      vecs[24] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h01, 1'b1};
      vecs[25] = '{8'hFF, 2'd2, 1'b1, 8'h00, 8'h01, 1'b1};
      vecs[26] = '{8'hFF, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[27] = '{8'hFF, 2'd2, 1'b1, 8'h01, 8'h00, 1'b0};
      vecs[28] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h01, 1'b1};
      vecs[29] = '{8'hFF, 2'd3, 1'b1, 8'h01, 8'h01, 1'b1};
      vecs[30] = '{8'hFF, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0};

      reset_n = 1'b0;
      in_a = 8'hFF;    addr_a = 2'd0; cs_a = 1'b0; wrn_a = 1'b1; wd_a = 8'h00;
      in_b = 8'h00;    addr_b = 2'd0; cs_b = 1'b0; wrn_b = 1'b1; wd_b = 8'h00;
      in_c = 16'hFFFF; addr_c = 2'd0; cs_c = 1'b0; wrn_c = 1'b1; wd_c = 16'h0000;

      // Reset state
      repeat (2) tick();
      check("rst_rd_a", rd_a, 8'h00);
      check("rst_irq_a", irq_a, 1'b0);
      check("rst_rd_c", rd_c, 16'h0000);

      // Release with pins held high: DATA appears after init, no edge, no irq
      @(negedge clk);
      reset_n = 1'b1;
      tick(); tick(); tick();
      check("init_data_e3", rd_a, 8'h00);
      check("init_irq_e3", irq_a, 1'b0);
      tick();
      check("init_data_e4", rd_a, 8'hFF);
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("init_irq_%0d", i), irq_a, 1'b0);
      end
      addr_a = 2'd3;
      tick();
      check("init_edgecap", rd_a, 8'h00);

      // Table: rising capture, W1C, ignored writes, set-wins, mask gating
      for (int i = 0; i < 31; i++) begin
         in_a   = vecs[i].in;
         addr_a = vecs[i].addr;
         cs_a   = vecs[i].wr;
         wrn_a  = ~vecs[i].wr;
         wd_a   = vecs[i].wd;
         tick();
         check($sformatf("vec%0d_rd", i), rd_a, vecs[i].rd);
         check($sformatf("vec%0d_irq", i), irq_a, vecs[i].irq);
      end
      cs_a = 1'b0; wrn_a = 1'b1;

      // Instance C: any-edge capture on bit 15, write of zero leaves it set
      tick();
      check("c_data", rd_c, 16'hFFFF);
      addr_c = 2'd3;
      tick();
      check("c_cap_idle", rd_c, 16'h0000);
      in_c = 16'h7FFF;
      repeat (3) tick();
      in_c = 16'hFFFF;
      tick();
      check("c_cap_before", rd_c, 16'h0000);
      tick();
      check("c_cap_fall", rd_c, 16'h8000);
      repeat (4) tick();
      check("c_cap_hold", rd_c, 16'h8000);
      cs_c = 1'b1; wrn_c = 1'b0; wd_c = 16'h0000;
      tick();
      cs_c = 1'b0; wrn_c = 1'b1;
      tick();
      check("c_cap_wr0", rd_c, 16'h8000);
      cs_c = 1'b1; wrn_c = 1'b0; wd_c = 16'h8000;
      tick();
      cs_c = 1'b0; wrn_c = 1'b1;
      tick();
      check("c_cap_clr", rd_c, 16'h0000);
      check("c_irq", irq_c, 1'b0);

      // Instance B: 3-cycle glitch rejected
      in_b = 8'h01;
      repeat (3) tick();
      in_b = 8'h00;
      repeat (8) tick();
      check("b_glitch_data", rd_b, 8'h00);
      addr_b = 2'd3;
      tick();
      check("b_glitch_cap", rd_b, 8'h00);
      addr_b = 2'd0;

      // Instance B: held 4 cycles is accepted on the exact cycle
      in_b = 8'h01;
      repeat (6) tick();
      check("b_db_before", rd_b, 8'h00);
      tick();
      check("b_db_data", rd_b, 8'h01);
      addr_b = 2'd3;
      tick();
      check("b_db_cap", rd_b, 8'h01);
      check("b_db_irq", irq_b, 1'b0);

      // Instance B: capture 0F, enable all, then reset mid-debounce
      in_b = 8'h0F;
      repeat (10) tick();
      addr_b = 2'd2; cs_b = 1'b1; wrn_b = 1'b0; wd_b = 8'hFF;
      tick();
      cs_b = 1'b0; wrn_b = 1'b1; addr_b = 2'd3;
      tick();
      check("b_pre_cap", rd_b, 8'h0F);
      check("b_pre_irq", irq_b, 1'b1);
      in_b = 8'hFF;
      repeat (3) tick();
      #2 reset_n = 1'b0;
      #1;
      check("b_rst_rd", rd_b, 8'h00);
      check("b_rst_irq", irq_b, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("b_post_irq_%0d", i), irq_b, 1'b0);
      end
      tick();
      check("b_post_cap", rd_b, 8'h00);
      addr_b = 2'd2;
      tick();
      check("b_post_mask", rd_b, 8'h00);
      addr_b = 2'd0;
      tick();
      check("b_post_data", rd_b, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
